// File: rtl/gbe_tx_sync_fifo_if.sv
// gbe_tx_sync_fifo_if: write/read handshake and status bundle of the transmit-path FWFT FIFO
interface gbe_tx_sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_en;
  logic                  empty;
  logic                  prog_full;
  logic                  overflow;
  modport master (output din, wr_en, rd_en, input dout, empty, prog_full, overflow);
  modport slave  (input din, wr_en, rd_en, output dout, empty, prog_full, overflow);
endinterface

// File: rtl/gbe_tx_sync_fifo.sv
// gbe_tx_sync_fifo: single-clock first-word-fall-through FIFO with registered empty, prog_full and overflow flags
module gbe_tx_sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 11,
  parameter int PROG_FULL_THRESH = 1536
) (
  input logic             clk,
  input logic             rst,
  gbe_tx_sync_fifo_if.slave f
);
  localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic                  do_wr, do_rd;
  always_comb begin
    do_rd      = f.rd_en && count != '0;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
    do_wr      = f.wr_en && (count < DEPTH || do_rd);
    count_next = (do_wr && !do_rd) ? count + 1'b1 :
                 (do_rd && !do_wr) ? count - 1'b1 : count;
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= f.din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      f.empty     <= 1'b1;
      f.prog_full <= 1'b0;
      f.overflow  <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + ADDR_WIDTH'(do_wr);
      rd_ptr      <= rd_ptr + ADDR_WIDTH'(do_rd);
      count       <= count_next;
      f.empty     <= count_next == '0;
      f.prog_full <= count_next >= THRESH;
      f.overflow  <= f.wr_en && !do_wr;
    end
  end
  assign f.dout = mem[rd_ptr];
endmodule

// File: tb/tb_gbe_tx_sync_fifo.sv
// tb_gbe_tx_sync_fifo: directed and random stimulus against a queue-based reference of a depth-16 FIFO
module tb_gbe_tx_sync_fifo;
  localparam int DEPTH = 16;
  localparam int THR   = 12;
  logic clk = 0;
  logic rst = 1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] q[$];
  logic       ovf_exp = 0;
  logic       started = 0;
  gbe_tx_sync_fifo_if #(.DATA_WIDTH(8)) f ();
  gbe_tx_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PROG_FULL_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .f(f)
  );
  always #5 clk = ~clk;
  // reference: contents as a plain queue, acceptance decided from its size
  always @(posedge clk) begin
    bit rd, wr;
    started <= 1;
    if (rst) begin
      q.delete();
      ovf_exp <= 0;
    end else begin
      rd = f.rd_en && q.size() != 0;
      wr = f.wr_en && (q.size() < DEPTH || rd);
      ovf_exp <= f.wr_en && !wr;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(f.din);
    end
  end
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    check("empty", 8'(f.empty), 8'(q.size() == 0));
    check("prog_full", 8'(f.prog_full), 8'(q.size() >= THR));
    check("overflow", 8'(f.overflow), 8'(ovf_exp));
    if (q.size() != 0) check("dout", f.dout, q[0]);
  end
  task automatic step(logic w, logic [7:0] d, logic r);
    f.wr_en = w;
    f.din   = d;
    f.rd_en = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    f.wr_en = 0;
    f.rd_en = 0;
    f.din   = 0;
    rst     = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 0;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 8'(8'h40 + i), 0);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'hAA, 0);
    step(1, 8'hAB, 0);
    step(0, 0, 0);
    step(1, 8'h5A, 1);
    step(1, 8'hAC, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1);
    for (int n = 0; n < 40;) begin
      logic w, r;
      w = ($urandom_range(0, 1) == 1) && q.size() < DEPTH;
      r = $urandom_range(0, 2) != 0;
      if (w) n++;
      step(w, 8'($urandom), r);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0);
    rst = 1;
    step(0, 0, 0);
    rst = 0;
    step(0, 0, 0);
    step(1, 8'h77, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gbe_tx_sync_fifo.md
Name: gbe_tx_sync_fifo

Overview:
- Single-clock, parameterised first-word-fall-through (FWFT) FIFO with programmable-almost-full and overflow flags.
- Used in the GbE UDP transmit path in two instances:
  - packet-data buffer: 8-bit, deep;
  - per-packet control buffer: 64-bit {size[15:0], dest_port[15:0], dest_ip[31:0]}, shallow.
- The consumer reads the head word from dout while empty is low, before popping it.

Parameters:
- DATA_WIDTH, 8: width of din/dout. The control instance uses 64.
- ADDR_WIDTH, 11: log2 of depth; capacity = 2^ADDR_WIDTH words (default 2048).
- PROG_FULL_THRESH, 1536: occupancy at or above which prog_full asserts. Legal range 1..2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- dout  out  DATA_WIDTH  head-of-FIFO word (FWFT). Valid whenever empty=0.
- rd_en  in  1  pop request; acknowledges the word currently on dout.
- empty  out  1  high when occupancy is 0.
- prog_full  out  1  high when occupancy >= PROG_FULL_THRESH.
- overflow  out  1  one-cycle pulse: the previous cycle's write was dropped.

Behaviour:
- Storage:
  - Circular RAM of 2^ADDR_WIDTH words.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally modulo depth.
  - count is ADDR_WIDTH+1 bits.
- Reset (rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, prog_full=0, overflow=0.
  - RAM contents are not cleared. dout is don't-care while empty=1.
- Write acceptance:
  - do_wr = wr_en && (count < 2^ADDR_WIDTH || do_rd).
  - On do_wr: mem[wr_ptr] <= din and wr_ptr increments.
- Read acceptance:
  - do_rd = rd_en && count != 0.
  - On do_rd: rd_ptr increments.
  - rd_en while empty is ignored; no state change, no flag.
- count update: +1 on do_wr only, -1 on do_rd only, unchanged when both or neither.
- FWFT output:
  - dout = mem[rd_ptr] combinationally from the current pointer.
  - A word written at edge N is on dout, with empty=0, after edge N (a write into an empty FIFO appears one cycle later).
  - After a pop at edge N, the next word (if any) is on dout after edge N.
- Flags (all registered, updated at the same edge as count, reflecting the new count):
  - empty = (count_next == 0).
  - prog_full = (count_next >= PROG_FULL_THRESH).
  - overflow = wr_en && !do_wr. High for exactly the one cycle after each dropped write; consecutive drops give consecutive high cycles. Not sticky; upstream logic latches it.
- Full with a simultaneous read and write: both are accepted and count stays at max, so no overflow.
- Empty with a simultaneous read and write: the write is accepted, the read is ignored, count becomes 1.
- Reset mid-operation: all contents are discarded. The next cycle shows empty=1 and a subsequent write reappears as the first word.
- Data integrity: strict FIFO order across pointer wrap-around.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles (DATA_WIDTH=8) -> empty falls one cycle after the first write and dout=0x11. Pop three times -> dout shows 0x22 then 0x33, and empty=1 after the third pop.
- With ADDR_WIDTH=4, PROG_FULL_THRESH=12:
  - write 11 words -> prog_full=0;
  - 12th write -> prog_full=1 after that edge;
  - one pop -> prog_full=0.
- Fill all 16 words, then write 0xAA -> overflow=1 for exactly one cycle, count stays 16, and the 16 popped words match the original sequence without 0xAA.
- At full, assert wr_en and rd_en together with din=0x5A -> no overflow, count stays 16, and 0x5A is popped last.
- Stream 40 words through a depth-16 FIFO with random wr_en/rd_en (never overflowing) -> output sequence equals input sequence across pointer wrap.
- With 5 words stored, pulse rst -> empty=1, prog_full=0, overflow=0. Write 0x77 -> dout=0x77 with empty=0 after one cycle.
